// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the core front end.
//
// Picks the next fetch PC by priority: trap vector, exception return,
// branch/jump redirect, hold, sequential increment. Also keeps the
// saved trap PC (epc) and a circular return-address stack (RAS) that
// predicts the target of return instructions.
//
// Ports:
//   clk          in   clock
//   reset        in   asynchronous, active-low reset
//   stall        in   pipeline stall, holds the PC
//   fetch_ready  in   instruction memory accepts the current PC
//   fetch_valid  out  current PC is a valid fetch request
//   pc           out  current fetch PC (registered)
//   branch_taken in   conditional branch resolved taken
//   is_j_instr   in   direct jump
//   is_jr_instr  in   indirect jump
//   is_call      in   jump is a call, push return address
//   is_ret       in   indirect jump is a return, pop RAS
//   branch_pc    in   computed redirect target
//   trap         in   exception/interrupt taken
//   mret         in   return from trap
//   epc          out  saved trap PC
//   ras_count    out  number of valid RAS entries

module pc_gen #(
    parameter int                XLEN      = 32,
    parameter int                PC_STEP   = 1,
    parameter logic [XLEN-1:0]   RESET_PC  = '0,
    parameter logic [31:0]       TRAP_VEC  = 32'h10,
    parameter int                RAS_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall,
    input  logic                          fetch_ready,
    output logic                          fetch_valid,
    output logic [XLEN-1:0]               pc,
    input  logic                          branch_taken,
    input  logic                          is_j_instr,
    input  logic                          is_jr_instr,
    input  logic                          is_call,
    input  logic                          is_ret,
    input  logic [XLEN-1:0]               branch_pc,
    input  logic                          trap,
    input  logic                          mret,
    output logic [XLEN-1:0]               epc,
    output logic [$clog2(RAS_DEPTH):0]    ras_count
);

    localparam int              PTR_W   = $clog2(RAS_DEPTH);
    localparam int              CNT_W   = PTR_W + 1;
    localparam logic [XLEN-1:0] TRAP_PC = XLEN'(TRAP_VEC);
    localparam logic [XLEN-1:0] STEP    = XLEN'(PC_STEP);
    localparam logic [CNT_W-1:0] FULL   = CNT_W'(RAS_DEPTH);

    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_epc;
    logic             r_started;
    logic [XLEN-1:0]  r_ras [RAS_DEPTH];
    // r_ptr is the next free slot; the top of stack sits one below it.
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_adv;
    logic             w_redir;
    logic             w_pop;
    logic             w_push;
    logic [PTR_W-1:0] w_topIdx;
    logic [XLEN-1:0]  w_nextSeq;
    logic [XLEN-1:0]  w_target;

    always_comb begin
        fetch_valid = r_started & ~stall;
        w_adv       = fetch_valid & fetch_ready;
        w_redir     = branch_taken | is_j_instr | is_jr_instr;
        w_pop       = is_jr_instr & is_ret & (r_count != '0);
        w_push      = (is_j_instr | is_jr_instr) & is_call;
        w_topIdx    = r_ptr - PTR_W'(1);
        w_nextSeq   = r_pc + STEP;
        // A return with an empty stack falls back to the computed target.
        w_target    = w_pop ? r_ras[w_topIdx] : branch_pc;
    end

    // Redirect sources are flushes, so they bypass stall and fetch_ready.
    // The RAS only moves when the redirect is the selected source.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc      <= RESET_PC;
            r_epc     <= '0;
            r_started <= 1'b0;
            r_ptr     <= '0;
            r_count   <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_ras[i] <= '0;
            end
        end else begin
            r_started <= 1'b1;
            if (trap) begin
                r_pc  <= TRAP_PC;
                r_epc <= r_pc;
            end else if (mret) begin
                r_pc <= r_epc;
            end else if (w_redir) begin
                r_pc <= w_target;
                if (w_pop && w_push) begin
                    // jalr swap: pop then push collapses to replacing the top.
                    r_ras[w_topIdx] <= w_nextSeq;
                end else if (w_pop) begin
                    r_ptr   <= w_topIdx;
                    r_count <= r_count - CNT_W'(1);
                end else if (w_push) begin
                    // When full, r_ptr already points at the oldest entry.
                    r_ras[r_ptr] <= w_nextSeq;
                    r_ptr        <= r_ptr + PTR_W'(1);
                    if (r_count != FULL) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
            end else if (w_adv) begin
                r_pc <= w_nextSeq;
            end
        end
    end

    assign pc        = r_pc;
    assign epc       = r_epc;
    assign ras_count = r_count;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed self-checking bench for pc_gen.
// A default-parameter instance covers reset, stall, trap/mret and the RAS;
// a second instance with XLEN=8, PC_STEP=4 covers PC wrap-around.

module tb_pc_gen;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] pc;
    logic        branch_taken;
    logic        is_j_instr;
    logic        is_jr_instr;
    logic        is_call;
    logic        is_ret;
    logic [31:0] branch_pc;
    logic        trap;
    logic        mret;
    logic [31:0] epc;
    logic [2:0]  ras_count;

    logic        idle8;
    logic        ready8;
    logic        b8Taken;
    logic [7:0]  b8Pc;
    logic        fv8;
    logic [7:0]  pc8;
    logic [7:0]  epc8;
    logic [2:0]  rc8;

    int checks;
    int errors;

    pc_gen dut (
        .clk(clk), .reset(reset), .stall(stall), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .pc(pc), .branch_taken(branch_taken),
        .is_j_instr(is_j_instr), .is_jr_instr(is_jr_instr), .is_call(is_call),
        .is_ret(is_ret), .branch_pc(branch_pc), .trap(trap), .mret(mret),
        .epc(epc), .ras_count(ras_count)
    );

    pc_gen #(.XLEN(8), .PC_STEP(4)) dut8 (
        .clk(clk), .reset(reset), .stall(idle8), .fetch_ready(ready8),
        .fetch_valid(fv8), .pc(pc8), .branch_taken(b8Taken),
        .is_j_instr(idle8), .is_jr_instr(idle8), .is_call(idle8),
        .is_ret(idle8), .branch_pc(b8Pc), .trap(idle8), .mret(idle8),
        .epc(epc8), .ras_count(rc8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearStrobes();
        branch_taken = 0; is_j_instr = 0; is_jr_instr = 0;
        is_call = 0; is_ret = 0; trap = 0; mret = 0;
    endtask

    task automatic test_reset();
        reset = 0; stall = 0; fetch_ready = 1; branch_pc = '0;
        clearStrobes();
        tick(); tick();
        checks++; if (pc !== 32'd0) begin errors++; $display("[TB] FAIL reset_pc: got %h want 0", pc); end
        checks++; if (epc !== 32'd0) begin errors++; $display("[TB] FAIL reset_epc: got %h want 0", epc); end
        checks++; if (ras_count !== 3'd0) begin errors++; $display("[TB] FAIL reset_ras: got %0d want 0", ras_count); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_fv: got %b want 0", fetch_valid); end
        reset = 1;
        #1;
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL release_fv: got %b want 0", fetch_valid); end
        tick();
        checks++; if (pc !== 32'd0 || fetch_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL start: pc %h fv %b want 0/1", pc, fetch_valid);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (pc !== 32'(i)) begin errors++; $display("[TB] FAIL seq_pc: got %h want %h", pc, i); end
        end
    endtask

    task automatic test_stall();
        tick(); tick();
        checks++; if (pc !== 32'd5) begin errors++; $display("[TB] FAIL pre_stall: got %h want 5", pc); end
        stall = 1;
        #1;
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_fv: got %b want 0", fetch_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc !== 32'd5 || fetch_valid !== 1'b0) begin
                errors++; $display("[TB] FAIL stall_hold: pc %h fv %b want 5/0", pc, fetch_valid);
            end
        end
        branch_taken = 1; branch_pc = 32'h40;
        tick();
        branch_taken = 0;
        checks++; if (pc !== 32'h40) begin errors++; $display("[TB] FAIL stall_branch: got %h want 40", pc); end
        stall = 0;
    endtask

    task automatic test_trap();
        branch_taken = 1; branch_pc = 32'h20;
        tick();
        branch_taken = 0;
        trap = 1; mret = 1;
        tick();
        trap = 0;
        checks++; if (pc !== 32'h10 || epc !== 32'h20) begin
            errors++; $display("[TB] FAIL trap_mret: pc %h epc %h want 10/20", pc, epc);
        end
        tick();
        mret = 0;
        checks++; if (pc !== 32'h20) begin errors++; $display("[TB] FAIL mret: got %h want 20", pc); end
        checks++; if (ras_count !== 3'd0) begin errors++; $display("[TB] FAIL trap_ras: got %0d want 0", ras_count); end
    endtask

    task automatic test_ras();
        logic [31:0] expT [5];
        int          expC [5];
        expT = '{32'd42, 32'd32, 32'd22, 32'd12, 32'h99};
        expC = '{3, 2, 1, 0, 0};
        branch_taken = 1; branch_pc = 32'd1;
        tick();
        branch_taken = 0;
        for (int i = 0; i < 5; i++) begin
            is_j_instr = 1; is_call = 1;
            branch_pc = (i < 4) ? 32'(11 + 10 * i) : 32'd51;
            tick();
            checks++; if (ras_count !== 3'((i < 4) ? i + 1 : 4)) begin
                errors++; $display("[TB] FAIL call_count %0d: got %0d", i, ras_count);
            end
        end
        is_j_instr = 0; is_call = 0;
        checks++; if (pc !== 32'd51) begin errors++; $display("[TB] FAIL call_pc: got %h want 51", pc); end
        for (int i = 0; i < 5; i++) begin
            is_jr_instr = 1; is_ret = 1; branch_pc = 32'h99;
            tick();
            checks++; if (pc !== expT[i] || ras_count !== 3'(expC[i])) begin
                errors++; $display("[TB] FAIL ret %0d: pc %h cnt %0d want %h/%0d", i, pc, ras_count, expT[i], expC[i]);
            end
        end
        clearStrobes();
    endtask

    task automatic test_swap();
        is_j_instr = 1; is_call = 1; branch_pc = 32'h200;
        tick();
        clearStrobes();
        is_jr_instr = 1; is_call = 1; is_ret = 1; branch_pc = 32'h300;
        tick();
        clearStrobes();
        checks++; if (pc !== 32'h9A || ras_count !== 3'd1) begin
            errors++; $display("[TB] FAIL swap: pc %h cnt %0d want 9a/1", pc, ras_count);
        end
        branch_taken = 1; is_call = 1; is_ret = 1; branch_pc = 32'h400;
        tick();
        clearStrobes();
        checks++; if (pc !== 32'h400 || ras_count !== 3'd1) begin
            errors++; $display("[TB] FAIL branch_ignores_ras: pc %h cnt %0d want 400/1", pc, ras_count);
        end
        is_jr_instr = 1; is_ret = 1; branch_pc = 32'h99;
        tick();
        clearStrobes();
        checks++; if (pc !== 32'h201 || ras_count !== 3'd0) begin
            errors++; $display("[TB] FAIL swap_top: pc %h cnt %0d want 201/0", pc, ras_count);
        end
        is_call = 1; is_ret = 1;
        tick();
        clearStrobes();
        checks++; if (pc !== 32'h202 || ras_count !== 3'd0) begin
            errors++; $display("[TB] FAIL no_strobe: pc %h cnt %0d want 202/0", pc, ras_count);
        end
    endtask

    task automatic test_wrap();
        b8Taken = 1; b8Pc = 8'hFC;
        tick();
        b8Taken = 0;
        checks++; if (pc8 !== 8'hFC) begin errors++; $display("[TB] FAIL wrap_load: got %h want fc", pc8); end
        tick();
        checks++; if (pc8 !== 8'h00) begin errors++; $display("[TB] FAIL wrap: got %h want 00", pc8); end
        tick();
        checks++; if (pc8 !== 8'h04) begin errors++; $display("[TB] FAIL wrap_next: got %h want 04", pc8); end
    endtask

    task automatic test_reset_mid();
        is_j_instr = 1; is_call = 1; branch_pc = 32'h500;
        tick();
        clearStrobes();
        checks++; if (ras_count !== 3'd1) begin errors++; $display("[TB] FAIL pre_reset_ras: got %0d want 1", ras_count); end
        #3;
        reset = 0;
        #1;
        checks++; if (pc !== 32'd0 || ras_count !== 3'd0 || fetch_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL async_reset: pc %h cnt %0d fv %b want 0/0/0", pc, ras_count, fetch_valid);
        end
        checks++; if (epc !== 32'd0) begin errors++; $display("[TB] FAIL async_reset_epc: got %h want 0", epc); end
        tick();
        checks++; if (pc !== 32'd0) begin errors++; $display("[TB] FAIL reset_hold: got %h want 0", pc); end
        reset = 1;
    endtask

    initial begin
        checks = 0; errors = 0;
        idle8 = 0; ready8 = 1; b8Taken = 0; b8Pc = '0;
        test_reset();
        test_stall();
        test_trap();
        test_ras();
        test_swap();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator for the core front end, replacing the fixed 32-bit counter. Selects the next fetch PC by priority from five sources: trap vector, exception return, branch/jump redirect, hold, or sequential increment. Adds a fetch handshake toward instruction memory, an EPC register, and a circular return-address stack (RAS) that predicts return targets.

Parameters:
XLEN, 32, PC / address width
PC_STEP, 1, sequential increment (1 = word-addressed, 4 = byte-addressed)
RESET_PC, 0, PC value loaded during reset
TRAP_VEC, 32'h10, PC loaded on trap (truncated to XLEN)
RAS_DEPTH, 4, RAS entries; power of 2, >= 2

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
stall  in  1  pipeline stall; holds PC
fetch_ready  in  1  instruction memory accepts the current PC
fetch_valid  out  1  PC is a valid fetch request
pc  out  XLEN  current fetch PC (registered)
branch_taken  in  1  conditional branch resolved taken
is_j_instr  in  1  direct jump (jal)
is_jr_instr  in  1  indirect jump (jalr)
is_call  in  1  qualifies jump as call: push return address
is_ret  in  1  qualifies jr as return: pop RAS
branch_pc  in  XLEN  computed redirect target
trap  in  1  exception/interrupt taken
mret  in  1  return from trap
epc  out  XLEN  saved trap PC
ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries

Behaviour:
- Reset (reset=0, async): pc=RESET_PC, epc=0, ras_count=0, RAS pointer=0, started=0, fetch_valid=0.
- started sets on the first clk edge after reset deasserts. fetch_valid = started & !stall (combinational).
- adv = fetch_valid & fetch_ready.
- redir = branch_taken | is_j_instr | is_jr_instr.
- Next-PC priority, evaluated each clk edge:
  1. trap: pc<=TRAP_VEC; epc<=pc.
  2. mret: pc<=epc.
  3. redir: pc<=target, where target = RAS top if (is_jr_instr & is_ret & ras_count!=0), else branch_pc.
  4. !adv: pc holds.
  5. else: pc<=pc+PC_STEP, modulo 2^XLEN (wraps, no flag).
- Redirects (1-3) take effect regardless of stall or fetch_ready; they are flushes.
- Latency: one cycle from redirect input to new pc value.
- trap and mret together: trap wins; epc captures current pc.
- RAS acts only when priority-3 is the selected source. Trap and mret leave the RAS untouched.
- Push on (is_j_instr|is_jr_instr) & is_call: value = pc+PC_STEP.
- Pop on is_jr_instr & is_ret & ras_count!=0.
- Circular buffer. Push when full overwrites the oldest entry; ras_count saturates at RAS_DEPTH.
- Pop when empty: target = branch_pc; count stays 0; pointer unchanged.
- is_call & is_ret together (jalr swap): pop then push. Top is replaced with pc+PC_STEP; count unchanged. Target is the old top (or branch_pc if empty).
- is_call/is_ret without a jump strobe are ignored.
- Reset mid-operation: all state returns to reset values immediately, independent of clk.

Test Plan:
1. Reset release, stall=0, fetch_ready=1, PC_STEP=1 -> pc 0,1,2,3 on successive cycles; fetch_valid=0 in the first cycle after release, then 1.
2. stall=1 for 3 cycles at pc=5, then branch_taken with branch_pc=0x40 while stall=1 -> pc holds 5 for 3 cycles, then becomes 0x40; fetch_valid=0 throughout stall.
3. pc=0x20: trap and mret asserted together -> pc=0x10, epc=0x20. Next, mret alone -> pc=0x20.
4. RAS_DEPTH=4: five calls (is_j_instr+is_call) at pc 1,11,21,31,41 -> ras_count=4. Then five rets (is_jr_instr+is_ret, branch_pc=0x99) -> targets 42,32,22,12, then 0x99; ras_count 3,2,1,0,0.
5. XLEN=8, PC_STEP=4, pc=0xFC, advancing -> pc wraps to 0x00.
6. Reset asserted mid-stream between clock edges -> pc=RESET_PC, ras_count=0, fetch_valid=0 immediately.
